// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - opcodes, state codes, instruction layout and flag positions for exec_ctrl
package exec_ctrl_pkg;

  localparam logic [3:0] OP_NOT = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_RR  = 4'h6;
  localparam logic [3:0] OP_RL  = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hA;
  localparam logic [3:0] OP_LDI = 4'hB;
  localparam logic [3:0] OP_STA = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_JZ  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Bit positions inside flags_q = {z, cy, ov, p, s}
  localparam int FLAG_Z  = 4;
  localparam int FLAG_CY = 3;
  localparam int FLAG_OV = 2;
  localparam int FLAG_P  = 1;
  localparam int FLAG_S  = 0;

  typedef struct packed {
    logic [3:0] opcode;   // IR[15:12]
    logic [3:0] reg_sel;  // IR[11:8], low bits index the register bank
    logic [7:0] imm;      // IR[7:0]
  } instr_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_INC;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// rtl/exec_ctrl_if.sv - program ROM and ALU bus between exec_ctrl and its neighbours
interface exec_ctrl_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] rom_addr;
  logic [15:0]     rom_data;
  logic [3:0]      alu_instr_code;
  logic [7:0]      alu_in_data;
  logic [7:0]      alu_reg_file;
  logic [7:0]      alu_result;
  logic            alu_flag_z;
  logic            alu_flag_cy;
  logic            alu_flag_p;
  logic            alu_flag_s;

  modport master (
    output rom_addr, alu_instr_code, alu_in_data, alu_reg_file,
    input  rom_data, alu_result, alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s
  );

  modport slave (
    input  rom_addr, alu_instr_code, alu_in_data, alu_reg_file,
    output rom_data, alu_result, alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s
  );
endinterface

// File: rtl/exec_ctrl_reg_bank.sv
// rtl/exec_ctrl_reg_bank.sv - general register file, combinational read, synchronous write
module exec_ctrl_reg_bank #(
  parameter int REG_CNT = 8,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] regs [REG_CNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];
endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - three-cycle fetch/decode/execute controller driving the ALU
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int REG_CNT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  exec_ctrl_if.master     bus,
  output logic [7:0]      acc,
  output logic [4:0]      flags_q,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);
  localparam int IDX_W = $clog2(REG_CNT);

  logic [2:0]       state;
  instr_t           ir;
  logic [IDX_W-1:0] idx;
  logic [7:0]       reg_rdata;
  logic             reg_we;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  imm_pc;
  logic             unused_ir_bits;

  assign idx            = ir.reg_sel[IDX_W-1:0];
  assign unused_ir_bits = ^ir.reg_sel;
  assign pc_inc         = pc + PC_W'(1);
  assign imm_pc         = PC_W'(ir.imm);

  assign bus.rom_addr       = pc;
  assign bus.alu_instr_code = ir.opcode;
  assign bus.alu_in_data    = acc;
  assign bus.alu_reg_file   = reg_rdata;

  assign busy   = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted = (state == ST_HALT);

  // rst wins inside the bank as well, so an aborted STA never lands
  assign reg_we = (state == ST_EXEC) && (ir.opcode == OP_STA);

  exec_ctrl_reg_bank #(.REG_CNT(REG_CNT)) u_reg_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (reg_we),
    .waddr (idx),
    .wdata (acc),
    .raddr (idx),
    .rdata (reg_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ir      <= '0;
      acc     <= '0;
      flags_q <= '0;
      pc      <= '0;
    end else begin
      case (state)
        ST_IDLE:   if (start) state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= bus.rom_data;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          pc    <= pc_inc;
          if (is_alu_op(ir.opcode)) begin
            acc              <= bus.alu_result;
            flags_q[FLAG_Z]  <= bus.alu_flag_z;
            flags_q[FLAG_P]  <= bus.alu_flag_p;
            flags_q[FLAG_S]  <= bus.alu_flag_s;
            if (ir.opcode == OP_ADD) flags_q[FLAG_CY] <= bus.alu_flag_cy;
          end
          case (ir.opcode)
            OP_LDI: acc <= ir.imm;
            OP_JMP: pc  <= imm_pc;
            OP_JZ:  if (flags_q[FLAG_Z]) pc <= imm_pc;
            OP_HLT: state <= ST_HALT;
            default: ;
          endcase
        end
        ST_HALT:   if (start) state <= ST_FETCH;
        default:   state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - randomized and directed self-checking bench for exec_ctrl
module tb_exec_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] acc;
  logic [4:0] flags_q;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  exec_ctrl_if #(.PC_W(8)) bus ();

  exec_ctrl #(.PC_W(8), .REG_CNT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .acc     (acc),
    .flags_q (flags_q),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Reference ALU: returns {cy, result}; non-ALU codes give junk the controller must ignore
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return {1'b0, ~a};
      4'h1: return {1'b0, a ^ b};
      4'h2: return {1'b0, a | b};
      4'h3: return {1'b0, a & b};
      4'h4: return {1'b0, a} - {1'b0, b};
      4'h5: return {1'b0, a} + {1'b0, b};
      4'h6: return {a[0], a[0], a[7:1]};
      4'h7: return {a[7], a[6:0], a[7]};
      4'h8: return {1'b0, a - 8'd1};
      4'h9: return {1'b0, a + 8'd1};
      default: return 9'h15A;
    endcase
  endfunction

  always_comb begin
    logic [8:0] r;
    r = alu_fn(bus.alu_instr_code, bus.alu_in_data, bus.alu_reg_file);
    bus.alu_result  = r[7:0];
    bus.alu_flag_cy = r[8];
    bus.alu_flag_z  = (r[7:0] == 8'h00) || (bus.alu_instr_code > 4'h9);
    bus.alu_flag_p  = ~^r[7:0];
    bus.alu_flag_s  = r[7];
  end

  // Instruction-level model
  logic [7:0] m_acc;
  logic [7:0] m_r [8];
  logic [4:0] m_flags;
  logic [7:0] m_pc;
  bit         m_halt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_flags = 5'h00; m_pc = 8'h00; m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
  endtask

  task automatic model_step();
    logic [15:0] w;
    logic [3:0]  op;
    logic [2:0]  ix;
    logic [7:0]  nxt;
    logic [8:0]  r;
    w = rom[m_pc]; op = w[15:12]; ix = w[10:8]; nxt = m_pc + 8'd1;
    if (op <= 4'h9) begin
      r = alu_fn(op, m_acc, m_r[ix]);
      m_acc      = r[7:0];
      m_flags[4] = (r[7:0] == 8'h00);
      m_flags[1] = ~^r[7:0];
      m_flags[0] = r[7];
      if (op == 4'h5) m_flags[3] = r[8];
    end else begin
      case (op)
        4'hB: m_acc = w[7:0];
        4'hC: m_r[ix] = m_acc;
        4'hD: nxt = w[7:0];
        4'hE: if (m_flags[4]) nxt = w[7:0];
        4'hF: m_halt = 1'b1;
        default: ;
      endcase
    end
    m_pc = nxt;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_acc", acc, 0);
    check_eq("rst_flags", flags_q, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_halted", halted, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_halt = 1'b0;
  endtask

  // Entered at #1 into FETCH; leaves at #1 after the EXEC edge
  task automatic run_instr(input bit poke);
    logic [2:0] ix;
    check_eq("fetch_addr", bus.rom_addr, m_pc);
    check_eq("fetch_busy", busy, 1);
    @(posedge clk); #1;
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("exec_code", bus.alu_instr_code, rom[m_pc][15:12]);
    check_eq("exec_operand", bus.alu_in_data, m_acc);
    ix = rom[m_pc][10:8];
    @(posedge clk); #1;
    model_step();
    check_eq("acc", acc, m_acc);
    check_eq("flags", flags_q, m_flags);
    check_eq("pc", pc, m_pc);
    check_eq("halted", halted, m_halt);
    check_eq("busy", busy, !m_halt);
    check_eq("reg_read", bus.alu_reg_file, m_r[ix]);
  endtask

  task automatic run_n(input int n, input bit do_start, input bit rand_poke);
    if (do_start) pulse_start();
    for (int i = 0; i < n; i++) begin
      run_instr(rand_poke ? 1'($urandom_range(0, 1)) : 1'b0);
      if (m_halt && i < n - 1) pulse_start();
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_rom();
    do_reset();

    // LDI 5, STA R1, LDI 3, ADD R1, HLT
    rom[0] = 16'hB005; rom[1] = 16'hC100; rom[2] = 16'hB003; rom[3] = 16'h5100; rom[4] = 16'hF000;
    run_n(5, 1, 0);
    check_eq("prog1_acc", acc, 8'h08);
    check_eq("prog1_z", flags_q[4], 0);
    check_eq("prog1_pc", pc, 5);
    check_eq("prog1_halted", halted, 1);
    @(posedge clk); #1;
    check_eq("halt_hold_pc", pc, 5);

    // Carry set by ADD survives a following INC
    do_reset(); clear_rom();
    rom[0] = 16'hB0FF; rom[1] = 16'hC200; rom[2] = 16'hB001; rom[3] = 16'h5200; rom[4] = 16'h9000;
    run_n(4, 1, 0);
    check_eq("add_acc", acc, 8'h00);
    check_eq("add_flags", flags_q, 5'b11010);
    run_n(1, 0, 0);
    check_eq("inc_acc", acc, 8'h01);
    check_eq("inc_cy", flags_q[3], 1);

    // JZ uses the previously latched z
    do_reset(); clear_rom();
    rom[0] = 16'hB000; rom[1] = 16'h9000; rom[2] = 16'hE000;
    rom[3] = 16'hB001; rom[4] = 16'h8000; rom[5] = 16'hE010;
    run_n(3, 1, 0);
    check_eq("jz_not_taken", pc, 8'h03);
    run_n(3, 0, 0);
    check_eq("jz_taken", pc, 8'h10);

    // JMP to the top address, then wrap
    do_reset(); clear_rom();
    rom[0] = 16'hD0FF; rom[255] = 16'hD0FF;
    run_n(2, 1, 0);
    check_eq("jmp_ff", pc, 8'hFF);
    rom[255] = 16'hA000;
    run_n(1, 0, 0);
    check_eq("pc_wrap", pc, 8'h00);

    // Reset in EXEC of an ADD aborts the writeback
    do_reset(); clear_rom();
    rom[0] = 16'hB005; rom[1] = 16'hC100; rom[2] = 16'hB003; rom[3] = 16'h5100;
    run_n(3, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_acc", acc, 0);
    check_eq("abort_flags", flags_q, 0);
    check_eq("abort_pc", pc, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_halted", halted, 0);
    rst = 1'b0;
    model_reset();
    rom[0] = 16'h5100;
    run_n(1, 1, 0);
    check_eq("abort_r1_clear", acc, 0);

    // start together with rst
    do_reset(); clear_rom();
    run_n(2, 1, 0);
    start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check_eq("start_rst_busy", busy, 0);
    check_eq("start_rst_pc", pc, 0);
    @(posedge clk); #1;
    check_eq("start_rst_idle", busy, 0);
    model_reset();

    // Random programs with stray start pulses mid-instruction
    for (int p = 0; p < 6; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hA;
        rom[a] = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      end
      run_n(40, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
